// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared types and helpers for the pipeline hazard tracker: the per-stage
// record carried from D through E, M and W, and the Tnew countdown rule.
package pipe_hazard_tracker_pkg;

    localparam int TNEW_W = 2;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  a_rs;
        logic [REG_W-1:0]  a_rt;
        logic [REG_W-1:0]  awrite;
        logic [TNEW_W-1:0] tnew;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    // Tnew counts down one per stage and never wraps below zero.
    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

endpackage

// File: rtl/pipe_hazard_tracker_md_busy_counter.sv
// Mult/div busy window: a start while idle loads MD_LAT and the counter
// runs down to zero; starts while already busy are ignored.
module md_busy_counter #(
    parameter int MD_LAT = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic md_start,
    output logic md_busy
);

    localparam int MD_W = $clog2(MD_LAT + 1);

    logic [MD_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end else if (md_start) begin
            count <= MD_W'(MD_LAT);
        end
    end

    assign md_busy = (count != '0);

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Producer side of the hazard interface: carries destination/Tnew/source
// numbers from D through W, applies stall/flush, and tracks mult/div busy.
module pipe_hazard_tracker
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int MD_LAT = 5,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             validD,
    input  logic [4:0]       A_rsD,
    input  logic [4:0]       A_rtD,
    input  logic [4:0]       AwriteD,
    input  logic [1:0]       TnewD,
    input  logic             stallD,
    input  logic             flushE,
    input  logic             md_start,
    input  logic             md_useD,
    output logic [4:0]       A_rsE,
    output logic [4:0]       A_rtE,
    output logic [4:0]       A_rtM,
    output logic [4:0]       AwriteE,
    output logic [4:0]       AwriteM,
    output logic [4:0]       AwriteW,
    output logic [1:0]       TnewE,
    output logic [1:0]       TnewM,
    output logic [1:0]       TnewW,
    output logic             validE,
    output logic             validM,
    output logic             validW,
    output logic             md_busy,
    output logic             md_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    stage_t            d_rec;
    stage_t            e_q;
    logic              m_valid;
    logic [REG_W-1:0]  m_awrite;
    logic [REG_W-1:0]  m_rt;
    logic [TNEW_W-1:0] m_tnew;
    logic              w_valid;
    logic [REG_W-1:0]  w_awrite;
    logic [TNEW_W-1:0] w_tnew;

    // A bubble in D advertises nothing; a write to $0 never carries a Tnew.
    always_comb begin
        d_rec       = BUBBLE;
        d_rec.valid = validD;
        if (validD) begin
            d_rec.a_rs   = A_rsD;
            d_rec.a_rt   = A_rtD;
            d_rec.awrite = AwriteD;
        end
        d_rec.tnew = (d_rec.awrite == '0) ? '0 : TnewD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= BUBBLE;
        end else if (flushE) begin
            e_q <= BUBBLE;
        end else if (!stallD) begin
            e_q <= d_rec;
        end
    end

    // While E is held, M takes a bubble so the held instruction is not duplicated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid  <= 1'b0;
            m_awrite <= '0;
            m_rt     <= '0;
            m_tnew   <= '0;
        end else if (stallD && !flushE) begin
            m_valid  <= 1'b0;
            m_awrite <= '0;
            m_rt     <= '0;
            m_tnew   <= '0;
        end else begin
            m_valid  <= e_q.valid;
            m_awrite <= e_q.awrite;
            m_rt     <= e_q.a_rt;
            m_tnew   <= (e_q.awrite == '0) ? '0 : sat_dec(e_q.tnew);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_valid  <= 1'b0;
            w_awrite <= '0;
            w_tnew   <= '0;
        end else begin
            w_valid  <= m_valid;
            w_awrite <= m_awrite;
            w_tnew   <= (m_awrite == '0) ? '0 : sat_dec(m_tnew);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stallD && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flushE && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    md_busy_counter #(
        .MD_LAT (MD_LAT)
    ) u_md_busy (
        .clk      (clk),
        .reset_n  (reset_n),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    // A start in this cycle already blocks HI/LO users, before busy rises.
    assign md_stall = md_useD & (md_busy | md_start);

    assign A_rsE   = e_q.a_rs;
    assign A_rtE   = e_q.a_rt;
    assign AwriteE = e_q.awrite;
    assign TnewE   = e_q.tnew;
    assign validE  = e_q.valid;
    assign A_rtM   = m_rt;
    assign AwriteM = m_awrite;
    assign TnewM   = m_tnew;
    assign validM  = m_valid;
    assign AwriteW = w_awrite;
    assign TnewW   = w_tnew;
    assign validW  = w_valid;

endmodule
